param_seq_mult: RTL and testbench

PARAM_SEQ_MULT -- requirements
Module: param_seq_mult

---
 rtl/seq_mult_pkg.sv | 14 +
 rtl/mult_sign_conv.sv | 27 ++
 rtl/param_seq_mult.sv | 130 +++++++++++++
 tb/tb_param_seq_mult.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Imported by the sign converter and the multiplier top.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_SM = 1'b0;  // sign-magnitude
  localparam logic MODE_TC = 1'b1;  // two's complement

endpackage

// File: rtl/mult_sign_conv.sv
// Splits a W-bit operand into an unsigned W-bit magnitude and a sign bit
// according to the selected number format.
module mult_sign_conv
  import seq_mult_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0] operand_i,
  input  logic         mode_i,
  output logic [W-1:0] mag_o,
  output logic         sign_o
);

  // The most negative two's-complement value negates to 2^(W-1), which
  // still fits because the magnitude is treated as unsigned.
  always_comb begin
    sign_o = operand_i[W-1];
    if (mode_i == MODE_SM) begin
      mag_o = {1'b0, operand_i[W-2:0]};
    end else if (operand_i[W-1]) begin
      mag_o = -operand_i;
    end else begin
      mag_o = operand_i;
    end
  end

endmodule

// File: rtl/param_seq_mult.sv
// Sequential W-bit multiplier: one shift-add step per clock on operand
// magnitudes, with the sign applied when the result is registered.
module param_seq_mult
  import seq_mult_pkg::*;
#(
  parameter int W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W + 1);

  // Handshake: start is accepted only in IDLE or DONE; done is a one-cycle
  // pulse while product is valid; busy is high exactly while in CALC.

  state_e           state_q;
  logic             mode_q;
  logic             sign_q;
  logic [2*W-1:0]   mcand_q;
  logic [W-1:0]     mplier_q;
  logic [2*W-1:0]   acc_q;
  logic [CW-1:0]    cnt_q;
  logic [2*W-1:0]   product_q;
  logic [2*W-1:0]   product_d;
  logic             busy_q;
  logic             done_q;

  logic [W-1:0]     mag_a;
  logic [W-1:0]     mag_b;
  logic             sgn_a;
  logic             sgn_b;
  logic             load;

  mult_sign_conv #(.W(W)) u_conv_a (
    .operand_i (a),
    .mode_i    (mode),
    .mag_o     (mag_a),
    .sign_o    (sgn_a)
  );

  mult_sign_conv #(.W(W)) u_conv_b (
    .operand_i (b),
    .mode_i    (mode),
    .mag_o     (mag_b),
    .sign_o    (sgn_b)
  );

  assign load = start && ((state_q == IDLE) || (state_q == DONE));

  // Sign-magnitude never reports negative zero; two's complement negates
  // the full 2W-bit magnitude product.
  always_comb begin
    product_d = acc_q;
    if (mode_q == MODE_TC) begin
      if (sign_q) begin
        product_d = -acc_q;
      end
    end else begin
      product_d = {sign_q & (|acc_q), 1'b0, acc_q[2*W-3:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_SM;
      sign_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        state_q  <= CALC;
        mode_q   <= mode;
        sign_q   <= sgn_a ^ sgn_b;
        mcand_q  <= {{W{1'b0}}, mag_a};
        mplier_q <= mag_b;
        acc_q    <= '0;
        cnt_q    <= CW'(W);
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
          end
          CALC: begin
            if (cnt_q == '0) begin
              state_q   <= DONE;
              product_q <= product_d;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
              end
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
              cnt_q    <= cnt_q - CW'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_param_seq_mult.sv
// Self-checking bench for param_seq_mult at W=6 against an arithmetic
// reference model of both number formats.
module tb_param_seq_mult;

  localparam int W = 6;
  localparam int MAX_WAIT = 20;

  logic           clk;
  logic           rst;
  logic           start;
  logic           mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int errors;
  int checks;

  param_seq_mult #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: plain integer arithmetic on the operand values
  function automatic logic [2*W-1:0] ref_product(input logic m, input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
    int sx, sy, mx, my, p;
    logic [2*W-1:0] r;
    if (m) begin
      sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
      sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
      p  = sx * sy;
      r  = p[2*W-1:0];
    end else begin
      mx = int'(x) % (1 << (W - 1));
      my = int'(y) % (1 << (W - 1));
      p  = mx * my;
      r  = p[2*W-1:0];
      if ((x[W-1] != y[W-1]) && (p != 0)) r[2*W-1] = 1'b1;
    end
    return r;
  endfunction

  // driver: assumes the current time is just after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mult(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [2*W-1:0] res, output int lat, output logic busy_first);
    start = 1'b1;
    mode  = m;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    busy_first = busy;
    lat = 0;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    res = product;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    tick();
    tick();
    checks++;
    if ({busy, done, product} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b product=%h, required 0/0/000", busy, done, product);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    logic [2*W-1:0] res;
    int lat;
    logic bf;
    logic           vm[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0]   va[5]  = '{6'd63, 6'd32, 6'h3F, 6'd32, 6'd0};
    logic [W-1:0]   vb[5]  = '{6'd63, 6'd5, 6'd22, 6'd32, 6'd31};
    logic [2*W-1:0] vp[5]  = '{12'h3C1, 12'h000, 12'hFEA, 12'h400, 12'h000};
    for (int i = 0; i < 5; i++) begin
      do_mult(vm[i], va[i], vb[i], res, lat, bf);
      checks++;
      if (res !== vp[i]) begin
        errors++;
        $display("FAIL vector_%0d: product=%h, required %h", i, res, vp[i]);
      end
      checks++;
      if (lat != W + 1) begin
        errors++;
        $display("FAIL latency_%0d: done after %0d edges, required %0d", i, lat, W + 1);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL done_busy_%0d: busy=%0b in done cycle, required 0", i, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || product !== vp[i]) begin
        errors++;
        $display("FAIL done_pulse_%0d: done=%0b product=%h, required 0 and %h", i, done, product, vp[i]);
      end
      tick();
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    start = 1'b1; mode = 1'b1; a = 6'h3F; b = 6'd22;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; mode = 1'b0; a = 6'd5; b = 6'd7;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_calc: busy=%0b, required 1", busy);
    end
    tick();
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      tick();
      lat++;
    end
    checks++;
    if (product !== 12'hFEA || lat != W + 1) begin
      errors++;
      $display("FAIL busy_ignore: product=%h after %0d edges, required FEA after %0d", product, lat, W + 1);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_no_op: busy=%0b done=%0b, required 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] r1, r2;
    int lat;
    logic bf;
    do_mult(1'b1, 6'd7, 6'd9, r1, lat, bf);
    // start raised in the DONE cycle must reload immediately
    do_mult(1'b0, 6'd35, 6'd12, r2, lat, bf);
    checks++;
    if (bf !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_idle: busy=%0b after restart edge, required 1", bf);
    end
    checks++;
    if (r1 !== 12'd63 || r2 !== ref_product(1'b0, 6'd35, 6'd12) || lat != W + 1) begin
      errors++;
      $display("FAIL b2b_results: r1=%h r2=%h lat=%0d, required %h %h %0d", r1, r2, lat,
               12'd63, ref_product(1'b0, 6'd35, 6'd12), W + 1);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    start = 1'b1; mode = 1'b1; a = 6'd21; b = 6'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset_mid_calc: busy=%0b done=%0b product=%h, required 0/0/000", busy, done, product);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abort: %0d done pulses after reset, required 0", seen);
    end
    // reset and start together: reset wins
    rst = 1'b1; start = 1'b1; a = 6'd3; b = 6'd3;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start: busy=%0b, required 0", busy);
    end
    tick();
  endtask

  task automatic test_random();
    logic [2*W-1:0] res, exp_v;
    int lat, gap;
    logic bf, m;
    logic [W-1:0] x, y;
    for (int i = 0; i < 200; i++) begin
      m = 1'($urandom_range(0, 1));
      x = W'($urandom);
      y = W'($urandom);
      exp_v = ref_product(m, x, y);
      do_mult(m, x, y, res, lat, bf);
      checks++;
      if (res !== exp_v || lat != W + 1) begin
        errors++;
        $display("FAIL random m=%0b a=%h b=%h: product=%h lat=%0d, required %h lat=%0d",
                 m, x, y, res, lat, exp_v, W + 1);
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
    end
    tick();
  endtask

  task automatic test_sweep();
    logic [2*W-1:0] res;
    int lat;
    logic bf;
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < (1 << W); x++) begin
        for (int y = 0; y < (1 << W); y++) begin
          do_mult(m[0], x[W-1:0], y[W-1:0], res, lat, bf);
          checks++;
          if (res !== ref_product(m[0], x[W-1:0], y[W-1:0]) || lat != W + 1) begin
            errors++;
            $display("FAIL sweep m=%0d a=%0d b=%0d: product=%h lat=%0d, required %h lat=%0d",
                     m, x, y, res, lat, ref_product(m[0], x[W-1:0], y[W-1:0]), W + 1);
          end
        end
      end
    end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    #1;
    test_reset();
    test_vectors();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
